regfile_writeback: RTL

Write-side driver for the dual-bank (integer/float) `registerFile`, placed between the execute stages and the register file write port. It takes single-cycle writebacks from the integer pipeline and multi-cycle results from the FPU, and buffers FPU results in a small FIFO. It drives at most one registered write per cycle onto `writeReg`/`writeData`/`regWrite`/`float`. It also enforces write-after-write ordering and exposes a pending-write query for hazard logic.

---
 rtl/regfile_writeback.sv | 104 ++++++++++
 1 files changed

// File: rtl/regfile_writeback.sv
// rtl/regfile_writeback.sv - register file write-port driver merging integer writebacks with buffered FPU results
module regfile_writeback #(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             intValid,
    input  logic [4:0]       intReg,
    input  logic             intFloat,
    input  logic [31:0]      intData,
    input  logic             fpValid,
    output logic             fpReady,
    input  logic [4:0]       fpReg,
    input  logic [31:0]      fpData,
    input  logic [4:0]       queryReg,
    input  logic             queryFloat,
    output logic             queryHit,
    output logic [4:0]       writeReg,
    output logic [31:0]      writeData,
    output logic             regWrite,
    output logic             float,
    output logic [CNT_W-1:0] fifoCount,
    output logic             pending
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(FIFO_DEPTH);

    logic [4:0]            qReg  [FIFO_DEPTH];
    logic [31:0]           qData [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] qLive;
    logic [PTR_W-1:0]      wrPtr;
    logic [PTR_W-1:0]      rdPtr;
    logic                  push;
    logic                  pop;
    logic                  hit;

    // fpReady deliberately ignores a same-cycle pop so the full flag is purely registered state
    always_comb begin
        fpReady = !reset && (fifoCount < FULL_COUNT);
        push    = fpValid && fpReady;
        pop     = !intValid && (fifoCount != '0);
        pending = (fifoCount != '0);
    end

    // Live bits are cleared on pop, so only queued-and-not-squashed entries can hit
    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (qLive[i] && (qReg[i] == queryReg)) hit = 1'b1;
        end
        queryHit = hit && queryFloat;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wrPtr     <= '0;
            rdPtr     <= '0;
            fifoCount <= '0;
            qLive     <= '0;
            writeReg  <= '0;
            writeData <= '0;
            regWrite  <= 1'b0;
            float     <= 1'b0;
        end else begin
            // A newer float write kills older queued FPU results for the same register
            if (intValid && intFloat) begin
                for (int i = 0; i < FIFO_DEPTH; i++) begin
                    if (qLive[i] && (qReg[i] == intReg)) qLive[i] <= 1'b0;
                end
            end
            if (pop) begin
                qLive[rdPtr] <= 1'b0;
                rdPtr        <= rdPtr + 1'b1;
            end
            // Written after the squash loop so a same-cycle push survives it
            if (push) begin
                qReg[wrPtr]  <= fpReg;
                qData[wrPtr] <= fpData;
                qLive[wrPtr] <= 1'b1;
                wrPtr        <= wrPtr + 1'b1;
            end
            if (push && !pop) begin
                fifoCount <= fifoCount + 1'b1;
            end else if (pop && !push) begin
                fifoCount <= fifoCount - 1'b1;
            end

            if (intValid) begin
                writeReg  <= intReg;
                writeData <= intData;
                float     <= intFloat;
                regWrite  <= (intReg != 5'd0);
            end else if (pop) begin
                writeReg  <= qReg[rdPtr];
                writeData <= qData[rdPtr];
                float     <= 1'b1;
                regWrite  <= qLive[rdPtr] && (qReg[rdPtr] != 5'd0);
            end else begin
                regWrite  <= 1'b0;
            end
        end
    end
endmodule
